scsp_timer_bank: RTL and testbench

SCSP_TIMER_BANK -- requirements
Module: scsp_timer_bank

---
 rtl/scsp_timer_bank.sv | 128 ++++++++++++
 tb/tb_scsp_timer_bank.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scsp_timer_bank.sv
// rtl/scsp_timer_bank.sv - bank of sample-rate timers with prescaler, sticky pending flags and IRQ
//
// Purpose: NUM_TIMERS independent up-counters advanced by SAMPLE_CE through a
//   per-timer power-of-two prescaler (divide by 2^ctl). Counter wrap sets a
//   sticky pending flag and a one-cycle overflow strobe.
// Optional feature: define SCSP_TIMER_ONESHOT_EN to make timers loaded with
//   ONESHOT=1 halt at 0 after their first overflow until reloaded.
//
// Ports:
//   CLK        system clock
//   RST        asynchronous active-high reset
//   SAMPLE_CE  one-cycle pulse per output sample, acts as the counting enable
//   WR         per-timer load strobe (wins over SAMPLE_CE in the same cycle)
//   WDATA_CNT  shared counter load value
//   WDATA_CTL  shared prescaler select load value
//   ONESHOT    per-timer one-shot select, captured on WR
//   IEN        interrupt enable mask
//   ACK        per-timer pending clear strobe (overflow wins)
//   CNT        packed counter values, timer i at [i*CNT_W +: CNT_W]
//   PEND       sticky overflow pending flags
//   OVF_PULSE  one-cycle overflow strobe
//   IRQ        OR over timers of PEND & IEN (combinational)

`timescale 1ns/1ps

module scsp_timer_bank #(
  parameter int NUM_TIMERS = 3,
  parameter int CNT_W      = 8,
  parameter int PRE_W      = 3
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic                        SAMPLE_CE,
  input  logic [NUM_TIMERS-1:0]       WR,
  input  logic [CNT_W-1:0]            WDATA_CNT,
  input  logic [PRE_W-1:0]            WDATA_CTL,
  input  logic [NUM_TIMERS-1:0]       ONESHOT,
  input  logic [NUM_TIMERS-1:0]       IEN,
  input  logic [NUM_TIMERS-1:0]       ACK,
  output logic [NUM_TIMERS*CNT_W-1:0] CNT,
  output logic [NUM_TIMERS-1:0]       PEND,
  output logic [NUM_TIMERS-1:0]       OVF_PULSE,
  output logic                        IRQ
);

  // Largest divide ratio is 2^(2^PRE_W-1), so the prescaler needs that many bits.
  localparam int PS_W = (1 << PRE_W) - 1;

  for (genvar i = 0; i < NUM_TIMERS; i++) begin : g_timer
    logic [CNT_W-1:0] counter;
    logic [PRE_W-1:0] ctl;
    logic [PS_W-1:0]  prescaler;
    logic             halt;
    logic             oneshot;
    logic             pend;
    logic             ovf;

    logic [PS_W-1:0]  mask;
    logic             tick;
    logic             carry;
    logic             wrap;

    // mask has the low ctl bits set; ctl=0 gives an empty mask so every tick carries.
    for (genvar b = 0; b < PS_W; b++) begin : g_mask
      assign mask[b] = (ctl > PRE_W'(b));
    end

    assign tick  = SAMPLE_CE & ~WR[i] & ~halt;
    assign carry = &(prescaler | ~mask);
    assign wrap  = tick & carry & (&counter);

    always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
        counter   <= '0;
        ctl       <= '0;
        prescaler <= '0;
        halt      <= 1'b0;
        oneshot   <= 1'b0;
        pend      <= 1'b0;
        ovf       <= 1'b0;
      end else begin
        ovf <= wrap;

        if (WR[i]) begin
          counter   <= WDATA_CNT;
          ctl       <= WDATA_CTL;
          prescaler <= '0;
          halt      <= 1'b0;
          oneshot   <= ONESHOT[i];
        end else if (tick) begin
          if (carry) begin
            prescaler <= '0;
            counter   <= counter + CNT_W'(1);
          end else begin
            prescaler <= prescaler + PS_W'(1);
          end
        end

`ifdef SCSP_TIMER_ONESHOT_EN
        // The wrap already leaves the counter at 0; halting keeps it there.
        if (wrap && oneshot) begin
          halt <= 1'b1;
        end
`endif

        // A wrap in the same cycle as ACK keeps the flag set so no event is lost.
        if (wrap) begin
          pend <= 1'b1;
        end else if (ACK[i]) begin
          pend <= 1'b0;
        end
      end
    end

`ifndef SCSP_TIMER_ONESHOT_EN
    // Mode bit is still captured so the register map is identical in both builds.
    logic unused_oneshot;
    assign unused_oneshot = oneshot;
`endif

    assign CNT[i*CNT_W +: CNT_W] = counter;
    assign PEND[i]               = pend;
    assign OVF_PULSE[i]          = ovf;
  end

  assign IRQ = |(PEND & IEN);

endmodule

// File: tb/tb_scsp_timer_bank.sv
// tb/tb_scsp_timer_bank.sv - scoreboard testbench for scsp_timer_bank

`timescale 1ns/1ps

module tb_scsp_timer_bank;

  localparam int NT = 3;
  localparam int CW = 8;
  localparam int PW = 3;

  logic            CLK;
  logic            RST;
  logic            SAMPLE_CE;
  logic [NT-1:0]   WR;
  logic [CW-1:0]   WDATA_CNT;
  logic [PW-1:0]   WDATA_CTL;
  logic [NT-1:0]   ONESHOT;
  logic [NT-1:0]   IEN;
  logic [NT-1:0]   ACK;
  logic [NT*CW-1:0] CNT;
  logic [NT-1:0]   PEND;
  logic [NT-1:0]   OVF_PULSE;
  logic            IRQ;

  int checks = 0;
  int errors = 0;

  scsp_timer_bank #(.NUM_TIMERS(NT), .CNT_W(CW), .PRE_W(PW)) dut (
    .CLK(CLK), .RST(RST), .SAMPLE_CE(SAMPLE_CE), .WR(WR),
    .WDATA_CNT(WDATA_CNT), .WDATA_CTL(WDATA_CTL), .ONESHOT(ONESHOT),
    .IEN(IEN), .ACK(ACK), .CNT(CNT), .PEND(PEND), .OVF_PULSE(OVF_PULSE),
    .IRQ(IRQ)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference model state
  logic [CW-1:0] m_cnt  [NT];
  int            m_ctl  [NT];
  int            m_pre  [NT];
  logic          m_halt [NT];
  logic          m_os   [NT];
  logic          m_pend [NT];
  logic          m_ovf  [NT];

  typedef struct {
    logic [NT*CW-1:0] cnt;
    logic [NT-1:0]    pend;
    logic [NT-1:0]    ovf;
  } exp_t;

  exp_t sbq[$];

  task automatic model_reset();
    for (int i = 0; i < NT; i++) begin
      m_cnt[i] = '0; m_ctl[i] = 0; m_pre[i] = 0;
      m_halt[i] = 1'b0; m_os[i] = 1'b0; m_pend[i] = 1'b0; m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_step(input logic [NT-1:0] wr, input logic sce,
                            input logic [NT-1:0] ack, input logic [CW-1:0] wcnt,
                            input logic [PW-1:0] wctl, input logic [NT-1:0] os);
    for (int i = 0; i < NT; i++) begin
      int  mask;
      logic ov;
      mask = (1 << m_ctl[i]) - 1;
      ov   = 1'b0;
      if (wr[i]) begin
        m_cnt[i] = wcnt; m_ctl[i] = int'(wctl); m_pre[i] = 0;
        m_halt[i] = 1'b0; m_os[i] = os[i];
      end else if (sce && !m_halt[i]) begin
        if ((m_pre[i] & mask) == mask) begin
          m_pre[i] = 0;
          if (m_cnt[i] == 8'hFF) begin
            m_cnt[i] = 8'h00;
            ov = 1'b1;
`ifdef SCSP_TIMER_ONESHOT_EN
            if (m_os[i]) m_halt[i] = 1'b1;
`endif
          end else begin
            m_cnt[i] = m_cnt[i] + 8'd1;
          end
        end else begin
          m_pre[i] = m_pre[i] + 1;
        end
      end
      if (ov) m_pend[i] = 1'b1;
      else if (ack[i]) m_pend[i] = 1'b0;
      m_ovf[i] = ov;
    end
  endtask

  // Drive one clock cycle of stimulus, push the model's prediction, then check it.
  task automatic cycle(input logic [NT-1:0] wr, input logic sce, input logic [NT-1:0] ack,
                       input logic [CW-1:0] wcnt, input logic [PW-1:0] wctl,
                       input logic [NT-1:0] os);
    exp_t e;
    WR = wr; SAMPLE_CE = sce; ACK = ack;
    WDATA_CNT = wcnt; WDATA_CTL = wctl; ONESHOT = os;
    model_step(wr, sce, ack, wcnt, wctl, os);
    for (int i = 0; i < NT; i++) begin
      e.cnt[i*CW +: CW] = m_cnt[i];
      e.pend[i] = m_pend[i];
      e.ovf[i]  = m_ovf[i];
    end
    sbq.push_back(e);
    @(posedge CLK);
    #1;
    e = sbq.pop_front();
    checks++;
    if (CNT !== e.cnt) begin
      errors++;
      $display("FAIL sb_cnt: got %h expected %h", CNT, e.cnt);
    end
    checks++;
    if (PEND !== e.pend) begin
      errors++;
      $display("FAIL sb_pend: got %b expected %b", PEND, e.pend);
    end
    checks++;
    if (OVF_PULSE !== e.ovf) begin
      errors++;
      $display("FAIL sb_ovf: got %b expected %b", OVF_PULSE, e.ovf);
    end
    checks++;
    if (IRQ !== |(e.pend & IEN)) begin
      errors++;
      $display("FAIL sb_irq: got %b expected %b", IRQ, |(e.pend & IEN));
    end
    WR = '0; SAMPLE_CE = 1'b0; ACK = '0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if (CNT !== '0 || PEND !== '0 || OVF_PULSE !== '0 || IRQ !== 1'b0) begin
      errors++;
      $display("FAIL reset_init: cnt=%h pend=%b ovf=%b irq=%b expected all zero",
               CNT, PEND, OVF_PULSE, IRQ);
    end
    @(negedge CLK);
    RST = 1'b0;
    model_reset();
    IEN = 3'b111;
    // Get every timer pending, then reset asynchronously right after the overflow.
    cycle(3'b111, 1'b0, 3'b000, 8'hFF, 3'd0, 3'b000);
    cycle(3'b000, 1'b1, 3'b000, 8'h00, 3'd0, 3'b000);
    checks++;
    if (PEND !== 3'b111 || IRQ !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre: pend=%b irq=%b expected 111/1", PEND, IRQ);
    end
    #1;
    RST = 1'b1;
    #1;
    checks++;
    if (CNT !== '0 || PEND !== '0 || OVF_PULSE !== '0 || IRQ !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: cnt=%h pend=%b ovf=%b irq=%b expected all zero",
               CNT, PEND, OVF_PULSE, IRQ);
    end
    model_reset();
    @(negedge CLK);
    RST = 1'b0;
    // Divide-by-1 after reset: one tick moves every counter to 1.
    cycle(3'b000, 1'b1, 3'b000, 8'h00, 3'd0, 3'b000);
    checks++;
    if (CNT !== 24'h010101) begin
      errors++;
      $display("FAIL reset_restart: got %h expected 010101", CNT);
    end
  endtask

  task automatic test_overflow();
    IEN = 3'b001;
    cycle(3'b001, 1'b0, 3'b000, 8'hFE, 3'd0, 3'b000);
    cycle(3'b000, 1'b1, 3'b000, 8'h00, 3'd0, 3'b000);
    checks++;
    if (CNT[7:0] !== 8'hFF) begin
      errors++;
      $display("FAIL ovf_ff: got %h expected ff", CNT[7:0]);
    end
    cycle(3'b000, 1'b1, 3'b000, 8'h00, 3'd0, 3'b000);
    checks++;
    if (CNT[7:0] !== 8'h00 || PEND[0] !== 1'b1 || OVF_PULSE[0] !== 1'b1 || IRQ !== 1'b1) begin
      errors++;
      $display("FAIL ovf_wrap: cnt=%h pend=%b ovf=%b irq=%b expected 00/1/1/1",
               CNT[7:0], PEND[0], OVF_PULSE[0], IRQ);
    end
    cycle(3'b000, 1'b0, 3'b000, 8'h00, 3'd0, 3'b000);
    checks++;
    if (OVF_PULSE[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_pulse_width: got %b expected 0", OVF_PULSE[0]);
    end
    cycle(3'b001, 1'b0, 3'b000, 8'h20, 3'd0, 3'b000);
    checks++;
    if (PEND[0] !== 1'b1) begin
      errors++;
      $display("FAIL wr_keeps_pend: got %b expected 1", PEND[0]);
    end
  endtask

  task automatic test_prescaler();
    cycle(3'b010, 1'b0, 3'b000, 8'h00, 3'd3, 3'b000);
    for (int k = 1; k <= 64; k++) begin
      cycle(3'b000, 1'b1, 3'b000, 8'h00, 3'd0, 3'b000);
      if (k == 7) begin
        checks++;
        if (CNT[15:8] !== 8'h00) begin
          errors++;
          $display("FAIL pre_7: got %h expected 00", CNT[15:8]);
        end
      end
      if (k == 8) begin
        checks++;
        if (CNT[15:8] !== 8'h01) begin
          errors++;
          $display("FAIL pre_8: got %h expected 01", CNT[15:8]);
        end
      end
      if (k == 64) begin
        checks++;
        if (CNT[15:8] !== 8'h08) begin
          errors++;
          $display("FAIL pre_64: got %h expected 08", CNT[15:8]);
        end
      end
    end
    // Idle edges must not move counters or prescalers.
    cycle(3'b000, 1'b0, 3'b000, 8'h00, 3'd0, 3'b000);
    cycle(3'b000, 1'b0, 3'b000, 8'h00, 3'd0, 3'b000);
  endtask

  task automatic test_ack_vs_overflow();
    IEN = 3'b001;
    cycle(3'b000, 1'b0, 3'b001, 8'h00, 3'd0, 3'b000);
    checks++;
    if (PEND[0] !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear1: got %b expected 0", PEND[0]);
    end
    cycle(3'b001, 1'b0, 3'b000, 8'hFF, 3'd0, 3'b000);
    cycle(3'b000, 1'b1, 3'b001, 8'h00, 3'd0, 3'b000);
    checks++;
    if (PEND[0] !== 1'b1) begin
      errors++;
      $display("FAIL ack_vs_ovf: got %b expected 1", PEND[0]);
    end
    cycle(3'b000, 1'b0, 3'b001, 8'h00, 3'd0, 3'b000);
    checks++;
    if (PEND[0] !== 1'b0 || IRQ !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear2: pend=%b irq=%b expected 0/0", PEND[0], IRQ);
    end
  endtask

  task automatic test_wr_vs_tick();
    cycle(3'b100, 1'b1, 3'b000, 8'h10, 3'd0, 3'b000);
    checks++;
    if (CNT[23:16] !== 8'h10) begin
      errors++;
      $display("FAIL wr_vs_tick: got %h expected 10", CNT[23:16]);
    end
  endtask

  task automatic test_oneshot();
    int pulses;
    logic [CW-1:0] exp_cnt;
    pulses = 0;
`ifdef SCSP_TIMER_ONESHOT_EN
    exp_cnt = 8'h00;
`else
    exp_cnt = 8'h02;
`endif
    cycle(3'b001, 1'b0, 3'b000, 8'hFF, 3'd0, 3'b001);
    for (int k = 0; k < 3; k++) begin
      cycle(3'b000, 1'b1, 3'b000, 8'h00, 3'd0, 3'b000);
      if (OVF_PULSE[0] === 1'b1) pulses++;
    end
    checks++;
    if (CNT[7:0] !== exp_cnt) begin
      errors++;
      $display("FAIL oneshot_cnt: got %h expected %h", CNT[7:0], exp_cnt);
    end
    cycle(3'b000, 1'b0, 3'b000, 8'h00, 3'd0, 3'b000);
    if (OVF_PULSE[0] === 1'b1) pulses++;
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL oneshot_pulses: got %0d expected 1", pulses);
    end
  endtask

  initial begin
    RST = 1'b1; SAMPLE_CE = 1'b0; WR = '0; WDATA_CNT = '0; WDATA_CTL = '0;
    ONESHOT = '0; IEN = '0; ACK = '0;
    model_reset();
    test_reset();
    test_overflow();
    test_prescaler();
    test_ack_vs_overflow();
    test_wr_vs_tick();
    test_oneshot();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
